// File: rtl/vga_pkg.sv
// Shared VGA 640x480@60 timing constants and types.
// Used by the timing controller and its delay line.
package vga_pkg;

   localparam int H_VISIBLE = 640;
   localparam int H_FRONT   = 16;
   localparam int H_SYNC    = 96;
   localparam int H_BACK    = 48;
   localparam int H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;

   localparam int V_VISIBLE = 480;
   localparam int V_FRONT   = 10;
   localparam int V_SYNC    = 2;
   localparam int V_BACK    = 33;
   localparam int V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

   localparam int H_SYNC_START = H_VISIBLE + H_FRONT;
   localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;
   localparam int V_SYNC_START = V_VISIBLE + V_FRONT;
   localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;

   localparam int SCALE_SHIFT   = 2;
   localparam int COLOR_LATENCY = 1;

   localparam int SPRITE_W = 160;
   localparam int SPRITE_H = 120;

   localparam logic [7:0] X_OFF = 8'd255;
   localparam logic [6:0] Y_OFF = 7'd127;

   localparam int COLOR_R = 2;
   localparam int COLOR_G = 1;
   localparam int COLOR_B = 0;

   // Sync levels are stored as pin levels (active low).
   typedef struct packed {
      logic hs_n;
      logic vs_n;
      logic vis;
   } sync_t;

   localparam sync_t SYNC_IDLE = '{hs_n: 1'b1, vs_n: 1'b1, vis: 1'b0};

   function automatic logic [7:0] chan_level(
      input logic bit_on,
      input logic vis
   );
      return (bit_on && vis) ? 8'hFF : 8'h00;
   endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Fixed-depth shift register with a loadable reset value.
// Aligns sync/blank with the color pipeline.
module vga_delay_line #(
   parameter int DEPTH = 2,
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] rst_val,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   logic [WIDTH-1:0] stage_q [DEPTH];
   logic [WIDTH-1:0] stage_d [DEPTH];

   // Next value of each stage: shift by one position.
   always_comb begin
      stage_d[0] = din;
      for (int i = 1; i < DEPTH; i++) begin
         stage_d[i] = stage_q[i-1];
      end
   end

   // Stage registers, cleared to the supplied idle value.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            stage_q[i] <= rst_val;
         end
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            stage_q[i] <= stage_d[i];
         end
      end
   end

   assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/vga_timing_controller.sv
// 640x480@60 VGA timing with 160x120 sprite coordinates.
// Sync/blank are delayed to line up with registered RGB.
module vga_timing_controller
   import vga_pkg::*;
(
   input  logic       VGA_CLK,
   input  logic       reset,
   input  logic [2:0] color,
   output logic [7:0] xvga,
   output logic [6:0] yvga,
   output logic       frame_start,
   output logic       VGA_HS,
   output logic       VGA_VS,
   output logic       VGA_BLANK_N,
   output logic [7:0] VGA_R,
   output logic [7:0] VGA_G,
   output logic [7:0] VGA_B
);

   logic [9:0] hcount_q, hcount_d;
   logic [9:0] vcount_q, vcount_d;
   logic [7:0] xvga_q, xvga_d;
   logic [6:0] yvga_q, yvga_d;
   logic       frame_start_q, frame_start_d;
   logic       hs_q, hs_d;
   logic       vs_q, vs_d;
   logic       blank_n_q, blank_n_d;
   logic [7:0] r_q, r_d;
   logic [7:0] g_q, g_d;
   logic [7:0] b_q, b_d;

   logic       h_end;
   logic       visible;
   sync_t      raw_sync;
   sync_t      dly_sync;

   // Counter advance, raw sync decode and stage-1 coordinates.
   always_comb begin
      h_end    = (hcount_q == 10'(H_TOTAL - 1));
      hcount_d = h_end ? 10'd0 : hcount_q + 10'd1;
      vcount_d = vcount_q;
      if (h_end) begin
         if (vcount_q == 10'(V_TOTAL - 1)) begin
            vcount_d = 10'd0;
         end else begin
            vcount_d = vcount_q + 10'd1;
         end
      end

      visible = (hcount_q < 10'(H_VISIBLE))
             && (vcount_q < 10'(V_VISIBLE));

      raw_sync.hs_n = !((hcount_q >= 10'(H_SYNC_START))
                     && (hcount_q < 10'(H_SYNC_END)));
      raw_sync.vs_n = !((vcount_q >= 10'(V_SYNC_START))
                     && (vcount_q < 10'(V_SYNC_END)));
      raw_sync.vis  = visible;

      xvga_d = visible ? 8'(hcount_q >> SCALE_SHIFT) : X_OFF;
      yvga_d = visible ? 7'(vcount_q >> SCALE_SHIFT) : Y_OFF;
      frame_start_d = (hcount_q == 10'd0) && (vcount_q == 10'd0);
   end

   // Sync/visible arrive here one cycle before the output register,
   // i.e. in the same cycle the combiner presents the pixel's color.
   vga_delay_line #(
      .DEPTH (COLOR_LATENCY + 1),
      .WIDTH ($bits(sync_t))
   ) u_sync_dly (
      .clk     (VGA_CLK),
      .reset   (reset),
      .rst_val (SYNC_IDLE),
      .din     (raw_sync),
      .dout    (dly_sync)
   );

   // Output pin values: color masked by the aligned visible flag.
   always_comb begin
      hs_d      = dly_sync.hs_n;
      vs_d      = dly_sync.vs_n;
      blank_n_d = dly_sync.vis;
      r_d       = chan_level(color[COLOR_R], dly_sync.vis);
      g_d       = chan_level(color[COLOR_G], dly_sync.vis);
      b_d       = chan_level(color[COLOR_B], dly_sync.vis);
   end

   // All state registers with synchronous reset.
   always_ff @(posedge VGA_CLK) begin
      if (reset) begin
         hcount_q      <= 10'd0;
         vcount_q      <= 10'd0;
         xvga_q        <= 8'd0;
         yvga_q        <= 7'd0;
         frame_start_q <= 1'b0;
         hs_q          <= 1'b1;
         vs_q          <= 1'b1;
         blank_n_q     <= 1'b0;
         r_q           <= 8'h00;
         g_q           <= 8'h00;
         b_q           <= 8'h00;
      end else begin
         hcount_q      <= hcount_d;
         vcount_q      <= vcount_d;
         xvga_q        <= xvga_d;
         yvga_q        <= yvga_d;
         frame_start_q <= frame_start_d;
         hs_q          <= hs_d;
         vs_q          <= vs_d;
         blank_n_q     <= blank_n_d;
         r_q           <= r_d;
         g_q           <= g_d;
         b_q           <= b_d;
      end
   end

   assign xvga        = xvga_q;
   assign yvga        = yvga_q;
   assign frame_start = frame_start_q;
   assign VGA_HS      = hs_q;
   assign VGA_VS      = vs_q;
   assign VGA_BLANK_N = blank_n_q;
   assign VGA_R       = r_q;
   assign VGA_G       = g_q;
   assign VGA_B       = b_q;

endmodule

// File: tb/tb_vga_timing_controller.sv
// Randomized bench for vga_timing_controller against a
// pixel-index reference model of the VGA raster.
module tb_vga_timing_controller;

   logic       clk = 1'b0;
   logic       reset;
   logic [2:0] color;
   logic [7:0] xvga;
   logic [6:0] yvga;
   logic       frame_start;
   logic       VGA_HS;
   logic       VGA_VS;
   logic       VGA_BLANK_N;
   logic [7:0] VGA_R;
   logic [7:0] VGA_G;
   logic [7:0] VGA_B;

   int checks   = 0;
   int failures = 0;

   always #20 clk = ~clk;

   vga_timing_controller dut (
      .VGA_CLK     (clk),
      .reset       (reset),
      .color       (color),
      .xvga        (xvga),
      .yvga        (yvga),
      .frame_start (frame_start),
      .VGA_HS      (VGA_HS),
      .VGA_VS      (VGA_VS),
      .VGA_BLANK_N (VGA_BLANK_N),
      .VGA_R       (VGA_R),
      .VGA_G       (VGA_G),
      .VGA_B       (VGA_B)
   );

   task automatic chk(
      input string       tag,
      input logic [31:0] got,
      input logic [31:0] exp
   );
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d @%0t", tag, got, exp, $time);
      end
   endtask

   initial begin
      int         t;
      int         cyc;
      int         k;
      int         h;
      int         v;
      int         hs_run;
      int         mid_at;
      bit         vis;
      bit         mid_done;
      bit         hs_prev;
      logic [2:0] colh [8];
      logic [2:0] c;
      int         exp_x, exp_y, exp_fs;
      int         exp_hs, exp_vs, exp_bn;
      int         exp_r, exp_g, exp_b;

      t        = 0;
      cyc      = 0;
      hs_run   = 0;
      hs_prev  = 1'b1;
      mid_done = 1'b0;
      mid_at   = 20 * 800 + 700;
      for (int i = 0; i < 8; i++) colh[i] = 3'b000;
      reset = 1'b1;
      color = 3'b000;

      repeat (41000) begin
         @(posedge clk);
         if (reset) t = 0;
         else       t++;
         #1;

         // Reference: cycle t shows coordinates for pixel t-1
         // and pins for pixel t-3, pixel p at (p%800, p/800).
         exp_x = 0; exp_y = 0; exp_fs = 0;
         if (t >= 1) begin
            k   = t - 1;
            h   = k % 800;
            v   = (k / 800) % 525;
            vis = (h < 640) && (v < 480);
            exp_x  = vis ? h / 4 : 255;
            exp_y  = vis ? v / 4 : 127;
            exp_fs = (h == 0 && v == 0) ? 1 : 0;
         end
         exp_hs = 1; exp_vs = 1; exp_bn = 0;
         exp_r  = 0; exp_g  = 0; exp_b  = 0;
         if (t >= 3) begin
            k   = t - 3;
            h   = k % 800;
            v   = (k / 800) % 525;
            vis = (h < 640) && (v < 480);
            c   = colh[(t - 1) % 8];
            exp_hs = (h >= 656 && h < 752) ? 0 : 1;
            exp_vs = (v >= 490 && v < 492) ? 0 : 1;
            exp_bn = vis ? 1 : 0;
            exp_r  = (vis && c[2]) ? 255 : 0;
            exp_g  = (vis && c[1]) ? 255 : 0;
            exp_b  = (vis && c[0]) ? 255 : 0;
            if (h / 4 == 10 && v / 4 == 5) begin
               chk("dir_r",  32'(VGA_R), 255);
               chk("dir_g",  32'(VGA_G), 0);
               chk("dir_b",  32'(VGA_B), 255);
               chk("dir_bn", 32'(VGA_BLANK_N), 1);
            end
         end

         chk("xvga",        32'(xvga),        exp_x);
         chk("yvga",        32'(yvga),        exp_y);
         chk("frame_start", 32'(frame_start), exp_fs);
         chk("hs",          32'(VGA_HS),      exp_hs);
         chk("vs",          32'(VGA_VS),      exp_vs);
         chk("blank_n",     32'(VGA_BLANK_N), exp_bn);
         chk("r",           32'(VGA_R),       exp_r);
         chk("g",           32'(VGA_G),       exp_g);
         chk("b",           32'(VGA_B),       exp_b);

         if (mid_done && t == 0) chk("mid_rst_hs", 32'(VGA_HS), 1);
         if (mid_done && t == 1) chk("mid_rst_fs", 32'(frame_start), 1);

         if (hs_prev && !VGA_HS) chk("hs_fall_h", 32'((t - 3) % 800), 656);
         if (!hs_prev && VGA_HS && t > 0) chk("hs_width", 32'(hs_run), 96);
         if (!VGA_HS) hs_run++;
         else         hs_run = 0;
         hs_prev = VGA_HS;

         // Inputs for the rest of cycle t.
         cyc++;
         reset = (cyc < 10);
         if (!mid_done && cyc >= 10 && t == mid_at) begin
            reset    = 1'b1;
            mid_done = 1'b1;
         end
         color = mid_done ? 3'b111 : 3'($urandom_range(0, 7));
         if (t >= 2) begin
            k = t - 2;
            h = k % 800;
            v = (k / 800) % 525;
            if (h / 4 == 10 && v / 4 == 5) color = 3'b101;
         end
         colh[t % 8] = color;
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
